// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the two-digit 7-segment scan driver.
// Optional feature macro (used in seg7_scan_driver): SEG7_LZ_BLANK_EN.
package seg7_pkg;

    // Scan sequence: blank before tens, tens lit, blank before units, units lit.
    typedef enum logic [1:0] {
        S_DEAD_T = 2'd0,
        S_TENS   = 2'd1,
        S_DEAD_U = 2'd2,
        S_UNITS  = 2'd3
    } state_t;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Active-low digit enables, [1]=tens, [0]=units.
    localparam logic [1:0] DIG_OFF   = 2'b11;
    localparam logic [1:0] DIG_TENS  = 2'b01;
    localparam logic [1:0] DIG_UNITS = 2'b10;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to 7-segment decoder; codes 10-15 show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one digit.
    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes two BCD digits onto one 7-segment bus with
// dead time between digits, frame-synchronous digit update and optional blinking.
// Optional feature macro: SEG7_LZ_BLANK_EN (blank a leading zero in the tens digit).
// Valid/ready note: there is no handshake; load is a fire-and-forget strobe that
// is sampled on every rising edge and never back-pressured.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEAD_DIV     = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_units,
    input  logic       load,
    input  logic       blink,
    output logic [6:0] seg,
    output logic [1:0] dig_n,
    output logic       frame_done,
    output logic [1:0] dbg_state
);

    // DEAD_DIV is below SCAN_DIV, so one phase counter sized for SCAN_DIV serves both.
    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES);
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] BLINK_HALF = FW'(BLINK_FRAMES / 2);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [7:0]      pend_q, pend_d;   // {tens, units}
    logic [7:0]      act_q, act_d;     // {tens, units}
    logic [6:0]      seg_q, seg_d;
    logic [1:0]      dig_q, dig_d;
    logic            fd_q, fd_d;
    logic            phase_last;
    logic            frame_start;
    logic            frame_end;
    logic [3:0]      digit_mux;
    logic [6:0]      dec_seg;

    // Registers; reset parks the scan at the first blank-before-tens cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_DEAD_T;
            cnt_q   <= '0;
            frame_q <= '0;
            pend_q  <= '0;
            act_q   <= '0;
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            fd_q    <= fd_d;
        end
    end

    // Phase sequencing, frame counting and the pending/active digit pipeline.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        phase_last = 1'b0;
        case (state_q)
            S_TENS, S_UNITS: phase_last = (cnt_q == SCAN_LAST);
            default:         phase_last = (cnt_q == DEAD_LAST);
        endcase
        if (phase_last) begin
            cnt_d = '0;
            case (state_q)
                S_DEAD_T: state_d = S_TENS;
                S_TENS:   state_d = S_DEAD_U;
                S_DEAD_U: state_d = S_UNITS;
                default:  state_d = S_DEAD_T;
            endcase
        end

        frame_end = (state_q == S_UNITS) && phase_last;
        frame_d   = frame_q;
        if (frame_end) begin
            frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + FW'(1);
        end
        fd_d = frame_end;

        // A load landing on the frame's first cycle bypasses pending straight to active.
        frame_start = (state_q == S_DEAD_T) && (cnt_q == '0);
        pend_d      = load ? {bcd_tens, bcd_units} : pend_q;
        act_d       = frame_start ? pend_d : act_q;
    end

    assign digit_mux = (state_q == S_TENS) ? act_q[7:4] : act_q[3:0];

    seg7_decode u_decode (
        .digit (digit_mux),
        .seg   (dec_seg)
    );

    // Output patterns, registered so they trail the scan state by one cycle.
    always_comb begin
        seg_d = SEG_OFF;
        dig_d = DIG_OFF;
        case (state_q)
            S_TENS: begin
                seg_d = dec_seg;
                dig_d = DIG_TENS;
`ifdef SEG7_LZ_BLANK_EN
                if (act_q[7:4] == 4'd0) begin
                    seg_d = SEG_OFF;
                    dig_d = DIG_OFF;
                end
`endif
            end
            S_UNITS: begin
                seg_d = dec_seg;
                dig_d = DIG_UNITS;
            end
            default: begin
                seg_d = SEG_OFF;
                dig_d = DIG_OFF;
            end
        endcase
        if (blink && (frame_q >= BLINK_HALF)) begin
            seg_d = SEG_OFF;
            dig_d = DIG_OFF;
        end
    end

    assign seg        = seg_q;
    assign dig_n      = dig_q;
    assign frame_done = fd_q;
    assign dbg_state  = state_q;

endmodule
